unidade_controle: RTL and testbench
===================================

# unidade_controle

Multicycle control FSM for the RV32 subset lw, sw, addi, add, sub, xor, srl and beq. It drives the ULA opcode (`ULAControl`) and every datapath mux and enable, and it consumes the ULA `flags` bus to resolve branches and, optionally, overflow traps. It sits between the instruction register and the shared ULA/memory datapath of the multicycle core.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; forces state FETCH.
- `op` in 7: instr[6:0].
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `flags` in 3: ULA flags from the current cycle. [2] is overflow, [1] is carry, [0] is zero.
- `ULAControl` out 3: 000 sub, 001 xor, 010 add, 011 srl, 100 beq-compare.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 register A.
- `ALUSrcB` out 2: 00 register B, 01 ImmExt, 10 constant 4.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ULA result.
- `ImmSrc` out 2: 00 I, 01 S, 10 B.
- `AdrSrc` out 1: 0 PC, 1 Result.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1 each: enables.
- `trap` out 1: overflow trap taken (sticky).
- `illegal` out 1: one-cycle pulse when DECODE sees an unsupported encoding.

## Operation
- The state register is 4 bits. Outputs are Moore-style decoded from state, except `PCWrite` in BEQ, which depends on `flags`.
- Any output not listed for a state is 0.
- **FETCH**
  - Outputs: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ULAControl=010, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- **DECODE**
  - Outputs: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ULAControl=010. This precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1100011 -> BEQ.
    - Unsupported encoding -> FETCH with `illegal`=1.
  - Supported encodings only:
    - lw/sw with funct3=010.
    - addi with funct3=000.
    - R-type add (funct3=000, f7b5=0), sub (000, 1), xor (100, 0), srl (101, 0).
    - beq with funct3=000.
- **MEMADR**
  - Outputs: ALUSrcA=10, ALUSrcB=01, ULAControl=010, ImmSrc=00 for lw or 01 for sw.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD**
  - Outputs: ResultSrc=00, AdrSrc=1.
  - Next state: MEMWB.
- **MEMWB**
  - Outputs: ResultSrc=01, RegWrite=1.
  - Next state: FETCH.
- **MEMWRITE**
  - Outputs: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - Next state: FETCH.
- **EXECUTER**
  - Outputs: ALUSrcA=10, ALUSrcB=00, ULAControl decoded from funct3/funct7b5.
  - Next state: ALUWB.
- **EXECUTEI**
  - Outputs: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ULAControl=010.
  - Next state: ALUWB.
- **ALUWB**
  - Outputs: ResultSrc=00, RegWrite=1.
  - Next state: FETCH.
- **BEQ**
  - Outputs: ALUSrcA=10, ALUSrcB=00, ULAControl=100, ResultSrc=00, PCWrite=`flags[0]`.
  - Next state: FETCH.
- `flags[1]` is ignored in all states. `flags` is ignored in every state other than BEQ and EXECUTER.

## Timing
- Reset value: state is FETCH. While `reset`=1, PCWrite, IRWrite, RegWrite, MemWrite, `trap` and `illegal` are all 0. The mux outputs show FETCH values.
- After reset deasserts, the first rising edge completes FETCH.
- Cycles per instruction, FETCH included:
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq: 3, taken or not.
  - Unsupported encoding: 2.
- Flags are sampled combinationally in the same cycle that ULAControl is driven. There is no added latency.
- Reset asserted mid-instruction aborts immediately, with no partial write. A write enable active in the same cycle is cut asynchronously.

## Configuration
- Macro `OVERFLOW_TRAP_EN`, defined:
  - In EXECUTER with add or sub, `flags[2]`=1 sends the FSM to TRAP instead of ALUWB.
  - TRAP holds `trap`=1 with all enables 0 until `reset`.
  - xor/srl never trap, because the ULA reports flags=000 for them.
- Macro undefined: no TRAP state exists, `trap` is tied to 0, and overflowing results are written back normally.

## Test plan
- Reset mid-MEMWRITE of sw -> MemWrite drops to 0 asynchronously. After release, cycle 1 is FETCH with IRWrite=1 and PCWrite=1.
- lw (op=0000011, funct3=010) -> 5 cycles. MEMADR drives ULAControl=010 and ImmSrc=00. MEMWB drives RegWrite=1 and ResultSrc=01. Next cycle is FETCH.
- R-type with funct3=101, f7b5=0 -> EXECUTER drives ULAControl=011. With funct3=000, f7b5=1 -> 000. With funct3=100 -> 001. RegWrite=1 exactly once.
- beq with flags=001 in BEQ -> PCWrite=1 for one cycle. With flags=000 -> PCWrite stays 0. Both cases take 3 cycles.
- op=1111111 -> `illegal` pulses for 1 cycle in DECODE, then FETCH, with no RegWrite or MemWrite.
- With `OVERFLOW_TRAP_EN`: sub with flags=100 in EXECUTER -> `trap`=1 and RegWrite never asserts, until reset clears it. Without the macro, the same stimulus produces ALUWB with RegWrite=1.

Source files
------------

// File: rtl/unidade_controle.sv
// Multicycle control FSM for the RV32 lw/sw/addi/add/sub/xor/srl/beq subset.
// Define OVERFLOW_TRAP_EN to add a sticky TRAP state on add/sub overflow.
module unidade_controle (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [2:0] flags,
    output logic [2:0] ULAControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       AdrSrc,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       trap,
    output logic       illegal
);

    localparam int unsigned ULA_W = 3;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [ULA_W-1:0] ULA_SUB = 3'b000;
    localparam logic [ULA_W-1:0] ULA_XOR = 3'b001;
    localparam logic [ULA_W-1:0] ULA_ADD = 3'b010;
    localparam logic [ULA_W-1:0] ULA_SRL = 3'b011;
    localparam logic [ULA_W-1:0] ULA_BEQ = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
`ifdef OVERFLOW_TRAP_EN
        S_BEQ      = 4'd9,
        S_TRAP     = 4'd10
`else
        S_BEQ      = 4'd9
`endif
    } state_t;

    state_t state_q, state_d;

    logic             legal_c;
    logic [ULA_W-1:0] r_ula_c;
    logic             pc_write_c, ir_write_c, reg_write_c, mem_write_c;
    logic             trap_c, illegal_c;

    // Only funct7b5 of funct7 is visible, so other funct7 bits are not checked
    always_comb begin
        legal_c = 1'b0;
        case (op)
            OP_LOAD, OP_STORE: legal_c = (funct3 == 3'b010);
            OP_IMM:            legal_c = (funct3 == 3'b000);
            OP_REG:            legal_c = (funct3 == 3'b000) ||
                                         (((funct3 == 3'b100) || (funct3 == 3'b101)) && !funct7b5);
            OP_BR:             legal_c = (funct3 == 3'b000);
            default:           legal_c = 1'b0;
        endcase
    end

    always_comb begin
        r_ula_c = ULA_ADD;
        case (funct3)
            3'b000:  r_ula_c = funct7b5 ? ULA_SUB : ULA_ADD;
            3'b100:  r_ula_c = ULA_XOR;
            3'b101:  r_ula_c = ULA_SRL;
            default: r_ula_c = ULA_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ULAControl  = ULA_SUB;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ImmSrc      = 2'b00;
        AdrSrc      = 1'b0;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        trap_c      = 1'b0;
        illegal_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                ALUSrcB    = 2'b10;
                ULAControl = ULA_ADD;
                ResultSrc  = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b10;
                ULAControl = ULA_ADD;
                if (!legal_c) begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_REG:            state_d = S_EXECUTER;
                        OP_IMM:            state_d = S_EXECUTEI;
                        default:           state_d = S_BEQ;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ULAControl = ULA_ADD;
                ImmSrc     = op[5] ? 2'b01 : 2'b00;
                state_d    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ULAControl = r_ula_c;
                state_d    = S_ALUWB;
`ifdef OVERFLOW_TRAP_EN
                if ((funct3 == 3'b000) && flags[2]) state_d = S_TRAP;
`endif
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ULAControl = ULA_ADD;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ULAControl = ULA_BEQ;
                pc_write_c = flags[0];
                state_d    = S_FETCH;
            end
`ifdef OVERFLOW_TRAP_EN
            S_TRAP: begin
                trap_c  = 1'b1;
                state_d = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Reset cuts every enable and status pulse immediately, not at the next edge
    assign PCWrite  = pc_write_c  & ~reset;
    assign IRWrite  = ir_write_c  & ~reset;
    assign RegWrite = reg_write_c & ~reset;
    assign MemWrite = mem_write_c & ~reset;
    assign trap     = trap_c      & ~reset;
    assign illegal  = illegal_c   & ~reset;

    // Carry is never consumed; overflow only matters with the trap feature
    logic unused_flags;
    assign unused_flags = ^flags[2:1];

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: walks each instruction class and checks
// every control output per cycle against hand-computed state vectors.
module tb_unidade_controle;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [2:0] flags;
    logic [2:0] ULAControl;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic       AdrSrc, PCWrite, IRWrite, RegWrite, MemWrite, trap, illegal;

    int vectors    = 0;
    int miscompares = 0;

    unidade_controle dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .flags      (flags),
        .ULAControl (ULAControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .AdrSrc     (AdrSrc),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .trap       (trap),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ULAControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc, PCWrite, IRWrite, RegWrite, MemWrite, trap, illegal}
    localparam logic [17:0] V_RESET    = 18'b010_00_10_10_00_0_0_0_0_0_0_0;
    localparam logic [17:0] V_FETCH    = 18'b010_00_10_10_00_0_1_1_0_0_0_0;
    localparam logic [17:0] V_DECODE   = 18'b010_01_01_00_10_0_0_0_0_0_0_0;
    localparam logic [17:0] V_ILLEGAL  = 18'b010_01_01_00_10_0_0_0_0_0_0_1;
    localparam logic [17:0] V_MEMADR_L = 18'b010_10_01_00_00_0_0_0_0_0_0_0;
    localparam logic [17:0] V_MEMADR_S = 18'b010_10_01_00_01_0_0_0_0_0_0_0;
    localparam logic [17:0] V_MEMREAD  = 18'b000_00_00_00_00_1_0_0_0_0_0_0;
    localparam logic [17:0] V_MEMWB    = 18'b000_00_00_01_00_0_0_0_1_0_0_0;
    localparam logic [17:0] V_MEMWRITE = 18'b000_00_00_00_00_1_0_0_0_1_0_0;
    localparam logic [17:0] V_EXR_SRL  = 18'b011_10_00_00_00_0_0_0_0_0_0_0;
    localparam logic [17:0] V_EXR_SUB  = 18'b000_10_00_00_00_0_0_0_0_0_0_0;
    localparam logic [17:0] V_EXR_XOR  = 18'b001_10_00_00_00_0_0_0_0_0_0_0;
    localparam logic [17:0] V_EXR_ADD  = 18'b010_10_00_00_00_0_0_0_0_0_0_0;
    localparam logic [17:0] V_EXI      = 18'b010_10_01_00_00_0_0_0_0_0_0_0;
    localparam logic [17:0] V_ALUWB    = 18'b000_00_00_00_00_0_0_0_1_0_0_0;
    localparam logic [17:0] V_BEQ_T    = 18'b100_10_00_00_00_0_1_0_0_0_0_0;
    localparam logic [17:0] V_BEQ_N    = 18'b100_10_00_00_00_0_0_0_0_0_0_0;
    localparam logic [17:0] V_TRAP     = 18'b000_00_00_00_00_0_0_0_0_0_1_0;

    logic [17:0] obs;
    assign obs = {ULAControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                  AdrSrc, PCWrite, IRWrite, RegWrite, MemWrite, trap, illegal};

    task automatic chk(input string tag, input logic [17:0] expected);
        vectors++;
        assert (obs === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expected);
        end
    endtask

    // Advance one clock and settle away from both edges
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    initial begin
        reset = 1'b1;
        set_instr(7'b0, 3'b0, 1'b0);
        flags = 3'b000;
        #3;
        chk("reset_state", V_RESET);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_fetch", V_FETCH);

        // lw: 5 cycles
        set_instr(7'b0000011, 3'b010, 1'b0);
        tick(); chk("lw_decode", V_DECODE);
        tick(); chk("lw_memadr", V_MEMADR_L);
        tick(); chk("lw_memread", V_MEMREAD);
        tick(); chk("lw_memwb", V_MEMWB);
        tick(); chk("lw_next_fetch", V_FETCH);

        // srl
        set_instr(7'b0110011, 3'b101, 1'b0);
        tick(); chk("srl_decode", V_DECODE);
        tick(); chk("srl_execr", V_EXR_SRL);
        tick(); chk("srl_aluwb", V_ALUWB);
        tick(); chk("srl_next_fetch", V_FETCH);

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        tick(); chk("sub_decode", V_DECODE);
        tick(); chk("sub_execr", V_EXR_SUB);
        tick(); chk("sub_aluwb", V_ALUWB);
        tick(); chk("sub_next_fetch", V_FETCH);

        // xor
        set_instr(7'b0110011, 3'b100, 1'b0);
        tick(); chk("xor_decode", V_DECODE);
        tick(); chk("xor_execr", V_EXR_XOR);
        tick(); chk("xor_aluwb", V_ALUWB);
        tick(); chk("xor_next_fetch", V_FETCH);

        // addi
        set_instr(7'b0010011, 3'b000, 1'b0);
        tick(); chk("addi_decode", V_DECODE);
        tick(); chk("addi_execi", V_EXI);
        tick(); chk("addi_aluwb", V_ALUWB);
        tick(); chk("addi_next_fetch", V_FETCH);

        // beq taken, zero flag already present in DECODE must not write PC
        set_instr(7'b1100011, 3'b000, 1'b0);
        flags = 3'b001;
        tick(); chk("beqt_decode", V_DECODE);
        tick(); chk("beqt_beq", V_BEQ_T);
        tick(); chk("beqt_next_fetch", V_FETCH);

        // beq not taken
        flags = 3'b000;
        tick(); chk("beqn_decode", V_DECODE);
        tick(); chk("beqn_beq", V_BEQ_N);
        tick(); chk("beqn_next_fetch", V_FETCH);

        // unsupported encodings: 2 cycles each
        set_instr(7'b1111111, 3'b000, 1'b0);
        tick(); chk("ill_op_decode", V_ILLEGAL);
        tick(); chk("ill_op_fetch", V_FETCH);
        set_instr(7'b0000011, 3'b000, 1'b0);
        tick(); chk("ill_lw_f3_decode", V_ILLEGAL);
        tick(); chk("ill_lw_f3_fetch", V_FETCH);
        set_instr(7'b0110011, 3'b100, 1'b1);
        tick(); chk("ill_xor_f7_decode", V_ILLEGAL);
        tick(); chk("ill_xor_f7_fetch", V_FETCH);

        // sw aborted by reset in MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0);
        tick(); chk("sw_decode", V_DECODE);
        tick(); chk("sw_memadr", V_MEMADR_S);
        tick(); chk("sw_memwrite", V_MEMWRITE);
        #1;
        reset = 1'b1;
        #1;
        chk("sw_reset_cut", V_RESET);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("sw_post_reset_fetch", V_FETCH);
        tick(); chk("sw_restart_decode", V_DECODE);
        tick(); chk("sw_restart_memadr", V_MEMADR_S);
        tick(); chk("sw_restart_memwrite", V_MEMWRITE);
        tick(); chk("sw_next_fetch", V_FETCH);

        // add with overflow
        set_instr(7'b0110011, 3'b000, 1'b0);
        flags = 3'b100;
        tick(); chk("ovf_add_decode", V_DECODE);
        tick(); chk("ovf_add_execr", V_EXR_ADD);
`ifdef OVERFLOW_TRAP_EN
        tick(); chk("ovf_add_trap", V_TRAP);
        tick(); chk("ovf_add_trap_hold", V_TRAP);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ovf_add_trap_reset", V_RESET);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ovf_add_trap_fetch", V_FETCH);
`else
        tick(); chk("ovf_add_aluwb", V_ALUWB);
        tick(); chk("ovf_add_next_fetch", V_FETCH);
`endif

        // sub with overflow
        set_instr(7'b0110011, 3'b000, 1'b1);
        tick(); chk("ovf_sub_decode", V_DECODE);
        tick(); chk("ovf_sub_execr", V_EXR_SUB);
`ifdef OVERFLOW_TRAP_EN
        tick(); chk("ovf_sub_trap", V_TRAP);
        tick(); chk("ovf_sub_trap_hold1", V_TRAP);
        tick(); chk("ovf_sub_trap_hold2", V_TRAP);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ovf_sub_trap_reset", V_RESET);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ovf_sub_trap_fetch", V_FETCH);
`else
        tick(); chk("ovf_sub_aluwb", V_ALUWB);
        tick(); chk("ovf_sub_next_fetch", V_FETCH);
`endif

        // xor with overflow flag set never traps
        flags = 3'b100;
        set_instr(7'b0110011, 3'b100, 1'b0);
        tick(); chk("ovf_xor_decode", V_DECODE);
        tick(); chk("ovf_xor_execr", V_EXR_XOR);
        tick(); chk("ovf_xor_aluwb", V_ALUWB);
        tick(); chk("ovf_xor_next_fetch", V_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
